// File: rtl/uart_frame_pkg.sv
// Shared frame constants and assembler FSM states, also used by the arbiter.
// Latency/backpressure: n/a (package only).
package uart_frame_pkg;
  localparam int FRAME_W = 16;
  localparam int BYTE_W  = 8;
  localparam logic [BYTE_W-1:0] CHECK_KEY = 8'h37;

  typedef enum logic {
    IDLE        = 1'b0,
    WAIT_SECOND = 1'b1
  } frame_state_t;

  // High byte of a frame is the low byte XORed with the key.
  function automatic logic frame_check(input logic [FRAME_W-1:0] f);
    return (f[BYTE_W-1:0] ^ CHECK_KEY) == f[FRAME_W-1:BYTE_W];
  endfunction
endpackage

// File: rtl/byte_gap_timer.sv
// Inter-byte gap counter; expired is combinational once GAP_CLKS-1 clocks have run.
// Holds at the limit and never backpressures.
module byte_gap_timer #(
  parameter int GAP_CLKS = 1740
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CNT_W = $clog2(GAP_CLKS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GAP_CLKS - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == LAST);
endmodule

// File: rtl/rx_frame_assembler.sv
// Pairs UART bytes into 16-bit frames and queues them; valid 1 clock after the second byte,
// frames pushed into a full queue are dropped. RX_FRAME_CHECKSUM_EN adds a per-entry o_frame_ok.
module rx_frame_assembler
  import uart_frame_pkg::*;
#(
  parameter int GAP_CLKS   = 1740,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_rx_dv,
  input  logic [BYTE_W-1:0]  i_rx_byte,
  input  logic               i_flush,
  output logic               o_frame_valid,
  output logic [FRAME_W-1:0] o_frame,
  input  logic               i_frame_ready,
`ifdef RX_FRAME_CHECKSUM_EN
  output logic               o_frame_ok,
`endif
  output logic               o_timeout,
  output logic               o_overflow,
  output logic [7:0]         o_drop_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  frame_state_t       state;
  logic [BYTE_W-1:0]  first_byte;
  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               expired;

  wire full        = (count == CNT_W'(FIFO_DEPTH));
  wire pop         = o_frame_valid && i_frame_ready;
  wire push_req    = (state == WAIT_SECOND) && i_rx_dv;
  wire push        = push_req && (!full || pop);
  wire overflow_ev = push_req && full && !pop;
  wire timeout_ev  = (state == WAIT_SECOND) && !i_rx_dv && expired;
  wire [FRAME_W-1:0] new_frame = {first_byte, i_rx_byte};

  byte_gap_timer #(.GAP_CLKS(GAP_CLKS)) u_gap (
    .clock   (clock),
    .reset   (reset),
    .clear   ((state == IDLE) || i_flush),
    .run     ((state == WAIT_SECOND) && !i_rx_dv),
    .expired (expired)
  );

  assign o_frame_valid = (count != '0);
  assign o_frame       = o_frame_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      first_byte   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      o_timeout    <= 1'b0;
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else begin
      o_timeout  <= 1'b0;
      o_overflow <= 1'b0;
      // Flush wins over everything, including a byte arriving this cycle.
      if (i_flush) begin
        state  <= IDLE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (i_rx_dv) begin
              first_byte <= i_rx_byte;
              state      <= WAIT_SECOND;
            end
          end
          WAIT_SECOND: begin
            if (i_rx_dv) begin
              state <= IDLE;
            end else if (expired) begin
              state     <= IDLE;
              o_timeout <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;

        if (overflow_ev) o_overflow <= 1'b1;
        if ((overflow_ev || timeout_ev) && (o_drop_count != 8'hFF))
          o_drop_count <= o_drop_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !i_flush && push) mem[wr_ptr] <= new_frame;
  end

`ifdef RX_FRAME_CHECKSUM_EN
  logic ok_mem [FIFO_DEPTH];

  always_ff @(posedge clock) begin
    if (!reset && !i_flush && push) ok_mem[wr_ptr] <= frame_check(new_frame);
  end

  assign o_frame_ok = o_frame_valid && ok_mem[rd_ptr];
`endif
endmodule

// File: doc/rx_frame_assembler.md
RX_FRAME_ASSEMBLER -- requirements
Module: rx_frame_assembler

Interface
REQ-001 SHALL have parameter GAP_CLKS, default 1740, the maximum clocks allowed between first and second byte of a frame (2 byte times at CLKS_PER_BIT=87).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the number of frame entries; power of two, range 2..8.
REQ-003 SHALL have ports: clock  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: i_rx_dv  in  1 (one-cycle strobe from uart_rx); i_rx_byte  in  8 (received byte, valid with i_rx_dv).
REQ-006 SHALL have ports: i_flush  in  1  clears the partial frame and the FIFO; driven by the arbiter on TIMEOUT.
REQ-007 SHALL have ports: o_frame_valid  out  1; o_frame  out  16 (FIFO head); i_frame_ready  in  1 (consumer accepts the head).
REQ-008 SHALL have ports: o_frame_ok  out  1 (checksum result for the head; present only under REQ-021).
REQ-009 SHALL have ports: o_timeout  out  1 pulse; o_overflow  out  1 pulse; o_drop_count  out  8 (saturating count of lost frames).

Function
REQ-010 SHALL run an FSM with states IDLE and WAIT_SECOND.
REQ-011 In IDLE, i_rx_dv SHALL latch i_rx_byte as frame bits [15:8] (check byte), clear the gap counter, and go to WAIT_SECOND.
REQ-012 In WAIT_SECOND, i_rx_dv SHALL form frame {first, i_rx_byte}, push it into the FIFO at that edge, and return to IDLE; o_frame_valid rises the next cycle if the FIFO was empty (latency 1 clock).
REQ-013 In WAIT_SECOND without i_rx_dv, the gap counter SHALL increment each clock. When it reaches GAP_CLKS-1, the partial byte is discarded, o_timeout pulses for 1 cycle, o_drop_count increments, and the FSM returns to IDLE.
REQ-014 If i_rx_dv coincides with the expiry cycle, the byte SHALL win: the frame completes and no timeout occurs.
REQ-015 A pop SHALL occur on any cycle with o_frame_valid=1 and i_frame_ready=1; o_frame SHALL show the oldest entry and hold stable while not popped.
REQ-016 A push into a full FIFO without a same-cycle pop SHALL drop the new frame, pulse o_overflow for 1 cycle and increment o_drop_count. A push with a same-cycle pop on a full FIFO SHALL succeed.
REQ-017 o_drop_count SHALL saturate at 255, with no wrap.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked in a counter of width clog2(FIFO_DEPTH)+1.
REQ-019 i_flush SHALL take priority over every event in its cycle, including push, pop and a coincident i_rx_dv byte, which is discarded. It empties the FIFO and sends the FSM to IDLE, but does not clear o_drop_count and does not pulse o_timeout or o_overflow.

Reset
REQ-020 Reset SHALL force the following, with priority over i_flush: FSM to IDLE; FIFO empty; o_frame_valid=0; o_frame=16'h0000; o_timeout=0; o_overflow=0; o_drop_count=0; o_frame_ok=0; gap counter=0. Reset mid-frame SHALL discard the partial byte silently.

Configuration
REQ-021 With macro RX_FRAME_CHECKSUM_EN defined, o_frame_ok SHALL be registered alongside each FIFO entry. Its value is ((frame[7:0] ^ CHECK_KEY) == frame[15:8]), with CHECK_KEY = 8'h37.
REQ-022 Without RX_FRAME_CHECKSUM_EN, the o_frame_ok port and its storage SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-023 Package uart_frame_pkg SHALL hold CHECK_KEY, FRAME_W=16, BYTE_W=8 and the FSM state enum, shared with the arbiter.
REQ-024 The gap counter SHALL be the sub-module byte_gap_timer, with ports clock, reset, clear, run, expired and a GAP_CLKS parameter.

Verification
REQ-025 Send bytes 8'h36, 8'h01 300 clocks apart -> o_frame=16'h3601 and o_frame_valid one clock after the second strobe; o_frame_ok=1 under the macro.
REQ-026 Send bytes 8'hAA, 8'h01 -> o_frame=16'hAA01 with o_frame_ok=0; with the macro undefined, the frame is identical and the port is absent.
REQ-027 Send byte 8'h12, then nothing for 1740 clocks -> one o_timeout pulse, o_drop_count=1, no frame; next pair 8'h37, 8'h00 -> frame 16'h3700.
REQ-028 Hold i_frame_ready=0 and send 3 frames with FIFO_DEPTH=2 -> first two frames retained in order, one o_overflow pulse, o_drop_count=1; then pop twice -> 16'h3601 then 16'h3502.
REQ-029 Assert i_flush in the same cycle as the second byte with 1 frame queued -> o_frame_valid=0 next cycle, FSM IDLE, o_drop_count unchanged.
REQ-030 Assert reset while in WAIT_SECOND -> all outputs at reset values next cycle; a following 2-byte frame assembles normally.
